// File: rtl/queue_read_arbiter_if.sv
// Handshake bundle between the queue, the read arbiter and its two consumers.
// The master modport is the arbiter side.
interface queue_read_arbiter_if;
  logic       queue_empty_in;
  logic [7:0] queue_data_in;
  logic       dequeue_out;
  logic [1:0] req_in;
  logic [1:0] ack_in;
  logic [1:0] valid_out;
  logic [7:0] data_out;
  logic       timeout_err_out;

  modport master (
    input  queue_empty_in,
    input  queue_data_in,
    input  req_in,
    input  ack_in,
    output dequeue_out,
    output valid_out,
    output data_out,
    output timeout_err_out
  );

  modport slave (
    output queue_empty_in,
    output queue_data_in,
    output req_in,
    output ack_in,
    input  dequeue_out,
    input  valid_out,
    input  data_out,
    input  timeout_err_out
  );
endinterface

// File: rtl/queue_read_arbiter.sv
// Round-robin arbiter that pops one byte per grant and offers it to a consumer.
// Define QUEUE_READ_ARBITER_TIMEOUT_EN to drop offers not acknowledged within 16 cycles.
module queue_read_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  queue_read_arbiter_if.master  bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    DELIVER = 1'b1
  } state_t;

  state_t     state;
  logic       grant;
  logic       last_grant;
  logic       pick;
  logic [1:0] valid_r;
  logic [7:0] data_r;
  logic       dequeue_r;

`ifdef QUEUE_READ_ARBITER_TIMEOUT_EN
  logic [3:0] timer;
  logic       timeout_err_r;
`endif

  // A tie goes to whichever consumer was not served last.
  always_comb begin
    pick = ~last_grant;
    unique case (bus.req_in)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last_grant;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      valid_r    <= '0;
      data_r     <= '0;
      dequeue_r  <= 1'b0;
`ifdef QUEUE_READ_ARBITER_TIMEOUT_EN
      timer         <= '0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      dequeue_r <= 1'b0;
`ifdef QUEUE_READ_ARBITER_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!bus.queue_empty_in && (bus.req_in != 2'b00)) begin
            grant     <= pick;
            data_r    <= bus.queue_data_in;
            valid_r   <= pick ? 2'b10 : 2'b01;
            dequeue_r <= 1'b1;
`ifdef QUEUE_READ_ARBITER_TIMEOUT_EN
            timer     <= '0;
`endif
            state     <= DELIVER;
          end else begin
            valid_r <= '0;
          end
        end
        DELIVER: begin
          // Ack on the granted bit wins over a simultaneous timer expiry.
          if (bus.ack_in[grant]) begin
            valid_r    <= '0;
            last_grant <= grant;
            state      <= IDLE;
          end
`ifdef QUEUE_READ_ARBITER_TIMEOUT_EN
          else if (timer == 4'hF) begin
            valid_r       <= '0;
            timeout_err_r <= 1'b1;
            last_grant    <= grant;
            state         <= IDLE;
          end else begin
            timer <= timer + 4'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid_out   = valid_r;
  assign bus.data_out    = data_r;
  assign bus.dequeue_out = dequeue_r;

`ifdef QUEUE_READ_ARBITER_TIMEOUT_EN
  assign bus.timeout_err_out = timeout_err_r;
`else
  assign bus.timeout_err_out = 1'b0;
`endif

endmodule

// File: doc/queue_read_arbiter.md
QUEUE_READ_ARBITER -- requirements
Module: queue_read_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port queue_empty_in  input  1  queue holds no bytes.
REQ-004 SHALL have port queue_data_in  input  8  head-of-queue byte, valid while queue_empty_in=0.
REQ-005 SHALL have port dequeue_out  output  1  one-cycle pop strobe to the queue (queue pops at the edge ending that cycle).
REQ-006 SHALL have port req_in  input  2  per-consumer read request, bit i = consumer i.
REQ-007 SHALL have port ack_in  input  2  per-consumer byte-taken acknowledge.
REQ-008 SHALL have port valid_out  output  2  one-hot: byte on data_out offered to consumer i; never more than one bit set.
REQ-009 SHALL have port data_out  output  8  registered byte delivered to granted consumer.
REQ-010 SHALL have port timeout_err_out  output  1  one-cycle pulse when an offered byte is dropped (see Configuration).

Function
REQ-011 SHALL implement FSM with states IDLE and DELIVER; all outputs registered.
REQ-012 IDLE: at an edge with queue_empty_in=0 and req_in!=0, SHALL grant one consumer, load data_out<=queue_data_in, set valid_out[g]<=1, dequeue_out<=1 and enter DELIVER.
REQ-013 IDLE with queue_empty_in=1 or req_in=0 SHALL remain idle with dequeue_out=0 and valid_out=0.
REQ-014 Arbitration SHALL be round-robin: single requester wins outright; when both request, the consumer not equal to last_grant wins.
REQ-015 dequeue_out SHALL be high for exactly the first DELIVER cycle and low otherwise; exactly one pop per grant.
REQ-016 DELIVER: valid_out[g] and data_out SHALL hold stable until an edge with ack_in[g]=1; then valid_out<=0, last_grant<=g, state<=IDLE.
REQ-017 ack_in on the non-granted bit, or any ack_in in IDLE, SHALL be ignored.
REQ-018 Deasserting req_in[g] during DELIVER SHALL NOT withdraw the offer; byte remains held until ack (or timeout).
REQ-019 Latency: request seen at edge N with non-empty queue -> valid_out at cycle N+1; ack in first DELIVER cycle permits the next grant one edge later (max 1 byte per 2 cycles).
REQ-020 Data SHALL be delivered in queue order; no byte duplicated or reordered.

Reset
REQ-021 rst=1 SHALL immediately force state=IDLE, valid_out=0, data_out=8'h00, dequeue_out=0, timeout_err_out=0, timer=0, last_grant=1 (consumer 0 wins first tie).
REQ-022 Reset during DELIVER SHALL discard the held byte without a further pop; no output asserts until the first edge after rst deasserts.

Configuration
REQ-023 Macro QUEUE_READ_ARBITER_TIMEOUT_EN SHALL compile in a 4-bit DELIVER-cycle timer.
REQ-024 With macro: timer clears on entering DELIVER, increments each DELIVER cycle without ack; if the 16th DELIVER cycle passes without ack_in[g], SHALL set valid_out<=0, pulse timeout_err_out for one cycle, last_grant<=g, return to IDLE (byte dropped, already popped).
REQ-025 With macro, ack_in[g] in the same cycle the timer expires SHALL take priority: normal completion, no error pulse.
REQ-026 Without macro: no timer logic, DELIVER waits indefinitely, timeout_err_out tied 0.

Verification
REQ-027 Queue holds 8'hA5, req_in=2'b01 -> next cycle valid_out=2'b01, data_out=8'hA5, dequeue_out=1 for one cycle; ack_in=2'b01 -> valid_out=0 next cycle.
REQ-028 Queue holds 8'h11,8'h22,8'h33,8'h44, req_in=2'b11 held, immediate acks -> grants 0,1,0,1 with data 11,22,33,44, one dequeue_out per byte.
REQ-029 req_in=2'b10, queue_empty_in=1 for 10 cycles -> dequeue_out and valid_out stay 0; queue becomes non-empty -> grant to consumer 1 next cycle.
REQ-030 Grant to consumer 0, drop req_in, send ack_in=2'b10 -> offer persists; ack_in=2'b01 after 5 cycles -> completion.
REQ-031 With QUEUE_READ_ARBITER_TIMEOUT_EN, no ack for 16 DELIVER cycles -> valid_out=0 and timeout_err_out=1 for one cycle; without macro, valid_out remains 2'b01 after 100 cycles.
REQ-032 Assert rst mid-DELIVER (valid_out=2'b10) -> valid_out, data_out, dequeue_out go 0 asynchronously; after release with req_in=2'b11 consumer 0 wins.
